// File: rtl/lb_gpio_ctrl.sv
// lb_gpio_ctrl: local-bus GPIO slave. It synchronizes and debounces the push-buttons,
// synchronizes the switches, latches button press events, and drives the LEDs and the
// LED-counter controls. Read data is zero when this block is not responding, so the
// top level can OR it with other slaves on the same bus.
module lb_gpio_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter logic [31:0] ID_VALUE        = 32'h4750_4901
) (
  input  logic        clk_lb,
  input  logic        reset_n,
  input  logic        lb_wr,
  input  logic        lb_rd,
  input  logic [31:0] lb_addr,
  input  logic [31:0] lb_wr_d,
  output logic [31:0] lb_rd_d,
  output logic        lb_rd_rdy,
  input  logic [4:0]  btn_in,
  input  logic [7:0]  sw_in,
  input  logic [7:0]  led_cnt_in,
  output logic [7:0]  led,
  output logic        cnt_reset,
  output logic        cnt_pause
);

  localparam int unsigned N_BTN = 5;
  localparam int unsigned N_SW  = 8;
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [7:0] ADDR_ID     = 8'h80;
  localparam logic [7:0] ADDR_STATUS = 8'h84;
  localparam logic [7:0] ADDR_EDGE   = 8'h88;
  localparam logic [7:0] ADDR_CTRL   = 8'h8C;

  // Button order is {d,u,r,l,c}: centre is bit 0, up is bit 3.
  localparam int unsigned BTN_C = 0;
  localparam int unsigned BTN_U = 3;

  logic [N_BTN-1:0] r_btn_s1, r_btn_s2, r_btn_db, r_edge;
  logic [N_SW-1:0]  r_sw_s1, r_sw_s2;
  logic [CNT_W-1:0] r_cnt [N_BTN];
  logic [2:0]       r_ctrl_flags;   // {sw_cnt_pause, sw_cnt_reset, led_override}
  logic [7:0]       r_led_val;
  logic [31:0]      r_rd_d;
  logic             r_rd_rdy;
  logic [7:0]       r_led;
  logic             r_cnt_reset, r_cnt_pause;

  logic [N_BTN-1:0] w_db_next, w_edge_rise, w_edge_clr;
  logic [CNT_W-1:0] w_cnt_next [N_BTN];
  logic [7:0]       w_addr;
  logic             w_wr_edge, w_wr_ctrl, w_rd_hit;
  logic [31:0]      w_rd_data;
  logic             w_unused;

  assign w_addr    = lb_addr[7:0];
  assign w_wr_edge = lb_wr && (w_addr == ADDR_EDGE);
  assign w_wr_ctrl = lb_wr && (w_addr == ADDR_CTRL);
  assign w_unused  = ^{lb_addr[31:8], lb_wr_d[31:16], lb_wr_d[7:5]};

  // Two-flop synchronizers for the asynchronous buttons and switches.
  always_ff @(posedge clk_lb or negedge reset_n) begin
    if (!reset_n) begin
      r_btn_s1 <= '0;
      r_btn_s2 <= '0;
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
    end else begin
      r_btn_s1 <= btn_in;
      r_btn_s2 <= r_btn_s1;
      r_sw_s1  <= sw_in;
      r_sw_s2  <= r_sw_s1;
    end
  end

  // Debounce: count while the synced value disagrees, accept it once the count saturates.
  always_comb begin
    w_db_next = r_btn_db;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      w_cnt_next[i] = '0;
      if (r_btn_s2[i] != r_btn_db[i]) begin
        if (r_cnt[i] == CNT_MAX) w_db_next[i] = r_btn_s2[i];
        else                     w_cnt_next[i] = r_cnt[i] + CNT_W'(1);
      end
    end
  end

  // Debounced state and counters.
  always_ff @(posedge clk_lb or negedge reset_n) begin
    if (!reset_n) begin
      r_btn_db <= '0;
      for (int unsigned i = 0; i < N_BTN; i++) r_cnt[i] <= '0;
    end else begin
      r_btn_db <= w_db_next;
      for (int unsigned i = 0; i < N_BTN; i++) r_cnt[i] <= w_cnt_next[i];
    end
  end

  assign w_edge_rise = w_db_next & ~r_btn_db;
  assign w_edge_clr  = w_wr_edge ? lb_wr_d[N_BTN-1:0] : '0;

  // Sticky press flags: W1C, a new rising edge wins over a same-cycle clear.
  always_ff @(posedge clk_lb or negedge reset_n) begin
    if (!reset_n) r_edge <= '0;
    else          r_edge <= (r_edge & ~w_edge_clr) | w_edge_rise;
  end

  // Control register.
  always_ff @(posedge clk_lb or negedge reset_n) begin
    if (!reset_n) begin
      r_ctrl_flags <= '0;
      r_led_val    <= '0;
    end else if (w_wr_ctrl) begin
      r_ctrl_flags <= lb_wr_d[2:0];
      r_led_val    <= lb_wr_d[15:8];
    end
  end

  // Read mux; undecoded addresses do not respond.
  always_comb begin
    w_rd_hit  = 1'b1;
    w_rd_data = '0;
    case (w_addr)
      ADDR_ID:     w_rd_data = ID_VALUE;
      ADDR_STATUS: w_rd_data = {16'h0, r_sw_s2, 3'b0, r_btn_db};
      ADDR_EDGE:   w_rd_data = {27'h0, r_edge};
      ADDR_CTRL:   w_rd_data = {16'h0, r_led_val, 5'h0, r_ctrl_flags};
      default:     w_rd_hit  = 1'b0;
    endcase
  end

  // Registered read response, zero when idle.
  always_ff @(posedge clk_lb or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_rdy <= 1'b0;
      r_rd_d   <= '0;
    end else begin
      r_rd_rdy <= lb_rd && w_rd_hit;
      r_rd_d   <= (lb_rd && w_rd_hit) ? w_rd_data : '0;
    end
  end

  // Registered LED and LED-counter controls.
  always_ff @(posedge clk_lb or negedge reset_n) begin
    if (!reset_n) begin
      r_led       <= '0;
      r_cnt_reset <= 1'b0;
      r_cnt_pause <= 1'b0;
    end else begin
      r_led       <= r_ctrl_flags[0] ? r_led_val : led_cnt_in;
      r_cnt_reset <= r_btn_db[BTN_C] | r_ctrl_flags[1];
      r_cnt_pause <= r_btn_db[BTN_U] | r_ctrl_flags[2];
    end
  end

  assign lb_rd_d   = r_rd_d;
  assign lb_rd_rdy = r_rd_rdy;
  assign led       = r_led;
  assign cnt_reset = r_cnt_reset;
  assign cnt_pause = r_cnt_pause;

endmodule
